pixel_frame_buffer: RTL and testbench

Parametrised single-clock frame buffer for lpGBT uplink dataframes: stores whole frames of `FRAME_W` bits in a `DEPTH`-frame circular buffer and presents them to the register interface as a word-serial stream of 32-bit words. It replaces fixed per-word register mapping with generic width/depth handling. It adds a snapshot capture mode, saturating overflow and FEC-error counters, and a fill-level report. It sits after the uplink clock-domain crossing, between the resynchronised uplink data and `axi4lite_interface_top` register decode.

---
 rtl/pixel_frame_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_pixel_frame_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_buffer.sv
// rtl/pixel_frame_buffer.sv - circular frame buffer with word-serial readout, snapshot capture and counters (optional: PIXBUF_ERR_COUNT_EN)
module pixel_frame_buffer #(
    parameter int FRAME_W = 234,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32,
    localparam int NWORDS = (FRAME_W + 31) / 32,
    localparam int AW     = $clog2(DEPTH),
    localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               frame_valid_i,
    input  logic               frame_err_i,
    input  logic               enable_i,
    input  logic               mode_i,
    input  logic               arm_i,
    input  logic [AW:0]        capture_len_i,
    input  logic               clear_i,
    input  logic               cnt_clr_i,
    input  logic               word_rd_i,
    output logic [31:0]        rd_word_o,
    output logic [WW-1:0]      rd_word_idx_o,
    output logic [AW:0]        level_o,
    output logic               empty_o,
    output logic               full_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   ovf_cnt_o,
    output logic [CNT_W-1:0]   err_cnt_o
);

    localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [WW-1:0] LAST_IDX = WW'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } snap_state_t;

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [WW-1:0]      idx;
    logic [AW:0]        level;
    logic [AW:0]        remaining;
    logic [AW:0]        remaining_nxt;
    logic [AW:0]        cap_len;
    snap_state_t        state;
    snap_state_t        state_nxt;
    logic [CNT_W-1:0]   ovf_cnt;
    logic [NWORDS*32-1:0] padded;

    logic flush;
    logic not_empty;
    logic is_full;
    logic rd_go;
    logic pop;
    logic want;
    logic wr_acc;
    logic ovf_hit;

    // Arming a snapshot flushes exactly like clear; a flush drops same-cycle reads and writes.
    assign flush     = clear_i || (mode_i && arm_i);
    assign not_empty = (level != '0);
    assign is_full   = (level == DEPTH_L);
    assign rd_go     = word_rd_i && not_empty && !flush;
    assign pop       = rd_go && (idx == LAST_IDX);
    assign want      = frame_valid_i && enable_i && (!mode_i || state == S_CAPTURE);
    assign wr_acc    = want && (!is_full || pop) && !flush;
    assign ovf_hit   = want && is_full && !pop && !flush;

    // Requested snapshot length clamped into 1..DEPTH.
    always_comb begin
        cap_len = capture_len_i;
        if (capture_len_i == '0) begin
            cap_len = (AW+1)'(1);
        end else if (capture_len_i > DEPTH_L) begin
            cap_len = DEPTH_L;
        end
    end

    // Snapshot next-state: stream mode parks in IDLE, arm always (re)starts a capture.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        if (!mode_i) begin
            state_nxt = S_IDLE;
        end else if (arm_i) begin
            state_nxt     = S_CAPTURE;
            remaining_nxt = cap_len;
        end else if (state == S_CAPTURE && wr_acc) begin
            if (remaining == (AW+1)'(1)) begin
                state_nxt = S_DONE;
            end else begin
                remaining_nxt = remaining - (AW+1)'(1);
            end
        end
    end

    // Snapshot state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state     <= S_IDLE;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Frame storage; contents are never reset, only the pointers are.
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= frame_i;
        end
    end

    // Pointers, word index and fill level.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            idx    <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            idx    <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_go) begin
                if (pop) begin
                    idx    <= '0;
                    rd_ptr <= rd_ptr + AW'(1);
                end else begin
                    idx <= idx + WW'(1);
                end
            end
            if (wr_acc && !pop) begin
                level <= level + (AW+1)'(1);
            end else if (pop && !wr_acc) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

    // Saturating count of frames dropped because the buffer was full.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ovf_cnt <= '0;
        end else if (cnt_clr_i) begin
            ovf_cnt <= '0;
        end else if (ovf_hit && ovf_cnt != '1) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

`ifdef PIXBUF_ERR_COUNT_EN
    logic [CNT_W-1:0] err_cnt;

    // Saturating count of accepted frames flagged with an FEC error.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            err_cnt <= '0;
        end else if (cnt_clr_i) begin
            err_cnt <= '0;
        end else if (wr_acc && frame_err_i && err_cnt != '1) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt_o = err_cnt;
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err_i;
    assign err_cnt_o        = '0;
`endif

    // Head frame zero-extended to whole words, then the current word selected; 0 when empty.
    always_comb begin
        padded              = '0;
        padded[FRAME_W-1:0] = mem[rd_ptr];
        rd_word_o           = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (not_empty && idx == WW'(w)) begin
                rd_word_o = padded[32*w +: 32];
            end
        end
    end

    assign rd_word_idx_o = idx;
    assign level_o       = level;
    assign empty_o       = !not_empty;
    assign full_o        = is_full;
    assign done_o        = (state == S_DONE);
    assign ovf_cnt_o     = ovf_cnt;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// tb/tb_pixel_frame_buffer.sv - randomized self-checking bench for pixel_frame_buffer
module tb_pixel_frame_buffer;

    localparam int FW  = 234;
    localparam int DEP = 4;
    localparam int CW  = 32;
    localparam int NW  = 8;
    localparam int AW  = 2;
    localparam int WW  = 3;
`ifdef PIXBUF_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [FW-1:0] frame_r;
    logic          valid_r, err_r, en_r, mode_r, arm_r, clear_r, cnt_clr_r, rd_r;
    logic [AW:0]   cap_r;
    logic [31:0]   rd_word;
    logic [WW-1:0] rd_idx;
    logic [AW:0]   level;
    logic          empty, full, done;
    logic [CW-1:0] ovf_cnt, err_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    logic [FW-1:0] m_q[$];
    int            m_idx  = 0;
    int            m_snap = 0;
    int            m_left = 0;
    logic [31:0]   m_ovf  = '0;
    logic [31:0]   m_err  = '0;

    pixel_frame_buffer #(.FRAME_W(FW), .DEPTH(DEP), .CNT_W(CW)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .frame_i       (frame_r),
        .frame_valid_i (valid_r),
        .frame_err_i   (err_r),
        .enable_i      (en_r),
        .mode_i        (mode_r),
        .arm_i         (arm_r),
        .capture_len_i (cap_r),
        .clear_i       (clear_r),
        .cnt_clr_i     (cnt_clr_r),
        .word_rd_i     (rd_r),
        .rd_word_o     (rd_word),
        .rd_word_idx_o (rd_idx),
        .level_o       (level),
        .empty_o       (empty),
        .full_o        (full),
        .done_o        (done),
        .ovf_cnt_o     (ovf_cnt),
        .err_cnt_o     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] rand_frame();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
        return t[FW-1:0];
    endfunction

    function automatic logic [31:0] word_of(logic [FW-1:0] f, int k);
        logic [255:0] t;
        t = '0;
        t[FW-1:0] = f;
        return t[32*k +: 32];
    endfunction

    function automatic logic [31:0] exp_word();
        if (m_q.size() == 0) return 32'd0;
        return word_of(m_q[0], m_idx);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_idx = 0; m_snap = 0; m_left = 0; m_ovf = '0; m_err = '0;
    endtask

    // Advance one clock: update the reference model from the current inputs, then clear pulses.
    task automatic step();
        bit flush, full_m, pop, want, acc, drop;
        int clamp;
        flush  = clear_r || (mode_r && arm_r);
        full_m = (m_q.size() == DEP);
        pop    = rd_r && m_q.size() > 0 && m_idx == NW-1 && !flush;
        want   = valid_r && en_r && (!mode_r || m_snap == 1);
        acc    = want && (!full_m || pop) && !flush;
        drop   = want && full_m && !pop && !flush;
        if (cnt_clr_r) begin
            m_ovf = '0; m_err = '0;
        end else begin
            if (drop && m_ovf != 32'hFFFF_FFFF) m_ovf++;
            if (ERR_EN && acc && err_r && m_err != 32'hFFFF_FFFF) m_err++;
        end
        if (flush) begin
            m_q.delete(); m_idx = 0;
        end else begin
            if (rd_r && m_q.size() > 0) begin
                if (m_idx == NW-1) begin void'(m_q.pop_front()); m_idx = 0; end
                else m_idx++;
            end
            if (acc) m_q.push_back(frame_r);
        end
        clamp = (cap_r == 0) ? 1 : ((int'(cap_r) > DEP) ? DEP : int'(cap_r));
        if (!mode_r) m_snap = 0;
        else if (arm_r) begin m_snap = 1; m_left = clamp; end
        else if (m_snap == 1 && acc) begin
            if (m_left == 1) m_snap = 2; else m_left--;
        end
        @(posedge clk); #1;
        valid_r = 0; err_r = 0; rd_r = 0; clear_r = 0; cnt_clr_r = 0; arm_r = 0;
    endtask

    task automatic write_frame(input logic [FW-1:0] f, input logic e);
        frame_r = f; valid_r = 1; err_r = e; step();
    endtask

    task automatic read_word();
        rd_r = 1; step();
    endtask

    task automatic prep();
        mode_r = 0; en_r = 1; clear_r = 1; cnt_clr_r = 1; step();
    endtask

    task automatic test_reset();
        rst_n = 0; frame_r = '0; valid_r = 0; err_r = 0; en_r = 1; mode_r = 0;
        arm_r = 0; cap_r = '0; clear_r = 0; cnt_clr_r = 0; rd_r = 0;
        #12;
        n_checks++; if (level !== 0) begin n_fails++; $display("FAIL reset_level got %0d want 0", level); end
        n_checks++; if (empty !== 1'b1) begin n_fails++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (full !== 1'b0 || done !== 1'b0) begin n_fails++; $display("FAIL reset_full_done got %b%b want 00", full, done); end
        n_checks++; if (ovf_cnt !== 0 || err_cnt !== 0) begin n_fails++; $display("FAIL reset_counters got %0d/%0d want 0/0", ovf_cnt, err_cnt); end
        n_checks++; if (rd_word !== 0 || rd_idx !== 0) begin n_fails++; $display("FAIL reset_word got %h idx %0d want 0", rd_word, rd_idx); end
        @(negedge clk); rst_n = 1;
        model_reset();
        step();
    endtask

    task automatic test_stream_roundtrip();
        logic [FW-1:0] a, b;
        prep();
        a = rand_frame(); b = rand_frame();
        write_frame(a, 0); write_frame(b, 0);
        n_checks++; if (level !== 2) begin n_fails++; $display("FAIL rt_level2 got %0d want 2", level); end
        for (int k = 0; k < NW; k++) begin
            n_checks++;
            if (rd_word !== word_of(a, k) || rd_idx !== WW'(k)) begin
                n_fails++; $display("FAIL rt_word_a%0d got %h idx %0d want %h", k, rd_word, rd_idx, word_of(a, k));
            end
            if (k == NW-1) begin
                n_checks++; if (rd_word[31:10] !== 22'd0) begin n_fails++; $display("FAIL rt_zero_ext got %h want upper 0", rd_word); end
            end
            read_word();
        end
        n_checks++; if (level !== 1) begin n_fails++; $display("FAIL rt_level1 got %0d want 1", level); end
        for (int k = 0; k < NW; k++) begin
            n_checks++;
            if (rd_word !== word_of(b, k)) begin n_fails++; $display("FAIL rt_word_b%0d got %h want %h", k, rd_word, word_of(b, k)); end
            read_word();
        end
        n_checks++; if (empty !== 1'b1 || rd_word !== 0) begin n_fails++; $display("FAIL rt_empty got %b/%h want 1/0", empty, rd_word); end
    endtask

    task automatic test_overflow();
        logic [FW-1:0] f[6];
        prep();
        for (int i = 0; i < 6; i++) begin f[i] = rand_frame(); write_frame(f[i], 0); end
        n_checks++; if (level !== 4 || full !== 1'b1) begin n_fails++; $display("FAIL ovf_level got %0d full %b want 4/1", level, full); end
        n_checks++; if (ovf_cnt !== 2) begin n_fails++; $display("FAIL ovf_count got %0d want 2", ovf_cnt); end
        for (int i = 0; i < 4; i++) begin
            int bad = 0;
            for (int k = 0; k < NW; k++) begin
                if (rd_word !== word_of(f[i], k)) bad++;
                read_word();
            end
            n_checks++; if (bad != 0) begin n_fails++; $display("FAIL ovf_frame%0d got %0d bad words want 0", i, bad); end
        end
    endtask

    task automatic test_full_pop();
        logic [FW-1:0] g[4];
        logic [FW-1:0] n;
        prep();
        for (int i = 0; i < 4; i++) begin g[i] = rand_frame(); write_frame(g[i], 0); end
        for (int k = 0; k < NW-1; k++) read_word();
        n = rand_frame();
        frame_r = n; valid_r = 1; rd_r = 1; step();
        n_checks++; if (level !== 4 || full !== 1'b1) begin n_fails++; $display("FAIL fp_level got %0d want 4", level); end
        n_checks++; if (ovf_cnt !== 0) begin n_fails++; $display("FAIL fp_ovf got %0d want 0", ovf_cnt); end
        n_checks++; if (rd_word !== word_of(g[1], 0) || rd_idx !== 0) begin n_fails++; $display("FAIL fp_head got %h want %h", rd_word, word_of(g[1], 0)); end
        for (int k = 0; k < 3*NW; k++) read_word();
        n_checks++; if (rd_word !== word_of(n, 0) || level !== 1) begin n_fails++; $display("FAIL fp_newframe got %h lvl %0d want %h lvl 1", rd_word, level, word_of(n, 0)); end
    endtask

    task automatic test_snapshot();
        logic [FW-1:0] s[10];
        prep();
        mode_r = 1; cap_r = 3; arm_r = 1; step();
        for (int i = 0; i < 10; i++) begin
            s[i] = rand_frame(); write_frame(s[i], 0);
            n_checks++;
            if (done !== (i >= 2)) begin n_fails++; $display("FAIL snap_done_%0d got %b want %b", i, done, i >= 2); end
        end
        n_checks++; if (level !== 3) begin n_fails++; $display("FAIL snap_level got %0d want 3", level); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_word !== word_of(s[i], 0)) begin n_fails++; $display("FAIL snap_frame%0d got %h want %h", i, rd_word, word_of(s[i], 0)); end
            for (int k = 0; k < NW; k++) read_word();
        end
        write_frame(rand_frame(), 0);
        arm_r = 1; step();
        n_checks++; if (level !== 0 || done !== 1'b0 || empty !== 1'b1) begin n_fails++; $display("FAIL snap_rearm got lvl %0d done %b want 0/0", level, done); end
        prep();
    endtask

    task automatic test_err_cnt();
        logic [CW-1:0] want5;
        prep();
        want5 = ERR_EN ? 32'd5 : 32'd0;
        for (int i = 0; i < 5; i++) begin
            write_frame(rand_frame(), 1);
            for (int k = 0; k < NW; k++) read_word();
        end
        n_checks++; if (err_cnt !== want5) begin n_fails++; $display("FAIL err_count got %0d want %0d", err_cnt, want5); end
        cnt_clr_r = 1; write_frame(rand_frame(), 1);
        n_checks++; if (err_cnt !== 0 || ovf_cnt !== 0) begin n_fails++; $display("FAIL err_clear got %0d/%0d want 0/0", err_cnt, ovf_cnt); end
    endtask

    task automatic test_clear_mid_read();
        prep();
        write_frame(rand_frame(), 0); write_frame(rand_frame(), 0);
        for (int k = 0; k < 3; k++) read_word();
        n_checks++; if (rd_idx !== 3) begin n_fails++; $display("FAIL clr_idx_before got %0d want 3", rd_idx); end
        clear_r = 1; rd_r = 1; step();
        n_checks++;
        if (level !== 0 || rd_idx !== 0 || rd_word !== 0 || empty !== 1'b1) begin
            n_fails++; $display("FAIL clr_state got lvl %0d idx %0d word %h want 0/0/0", level, rd_idx, rd_word);
        end
    endtask

    task automatic test_random();
        prep();
        cap_r = 2;
        for (int c = 0; c < 3000; c++) begin
            frame_r   = rand_frame();
            valid_r   = ($urandom_range(0, 99) < 55);
            err_r     = ($urandom_range(0, 99) < 30);
            en_r      = ($urandom_range(0, 99) < 92);
            rd_r      = ($urandom_range(0, 99) < 50);
            clear_r   = ($urandom_range(0, 99) < 2);
            cnt_clr_r = ($urandom_range(0, 199) < 2);
            arm_r     = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 2) mode_r = ~mode_r;
            if (arm_r) cap_r = (AW+1)'($urandom_range(0, 7));
            step();
            n_checks++;
            if (level !== (AW+1)'(m_q.size()) || rd_idx !== WW'(m_idx) || rd_word !== exp_word() ||
                empty !== (m_q.size() == 0) || full !== (m_q.size() == DEP) || done !== (m_snap == 2) ||
                ovf_cnt !== m_ovf || err_cnt !== m_err) begin
                n_fails++;
                $display("FAIL rand_cycle%0d got lvl %0d idx %0d word %h done %b ovf %0d err %0d want lvl %0d idx %0d word %h done %b ovf %0d err %0d",
                         c, level, rd_idx, rd_word, done, ovf_cnt, err_cnt,
                         m_q.size(), m_idx, exp_word(), m_snap == 2, m_ovf, m_err);
            end
        end
        en_r = 1;
        prep();
    endtask

    task automatic test_async_reset();
        prep();
        mode_r = 1; cap_r = 4; arm_r = 1; step();
        write_frame(rand_frame(), 1); write_frame(rand_frame(), 0);
        valid_r = 1; frame_r = rand_frame(); step(); // one more frame with an overflow-free capture
        read_word();
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        n_checks++;
        if (level !== 0 || empty !== 1'b1 || full !== 1'b0 || done !== 1'b0 ||
            rd_word !== 0 || rd_idx !== 0 || ovf_cnt !== 0 || err_cnt !== 0) begin
            n_fails++; $display("FAIL async_reset got lvl %0d idx %0d word %h done %b", level, rd_idx, rd_word, done);
        end
        model_reset();
        #2 rst_n = 1;
        valid_r = 1; frame_r = rand_frame(); step();
        n_checks++; if (level !== 0 || done !== 1'b0) begin n_fails++; $display("FAIL post_reset_idle got lvl %0d want 0", level); end
        prep();
    endtask

    initial begin
        test_reset();
        test_stream_roundtrip();
        test_overflow();
        test_full_pop();
        test_snapshot();
        test_err_cnt();
        test_clear_mid_read();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
